// File: rtl/forwarding_scoreboard_if.sv
// Bundle between the ID/EX hazard logic and the forwarding scoreboard.
// master: pipeline control side; slave: forwarding_scoreboard.
interface forwarding_scoreboard_if #(
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_FWD_STAGES  = 2,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int FWD_CODE_WIDTH  = 2,
    parameter int STALL_CNT_WIDTH = 16
);
    localparam int N  = NUM_READ_PORTS;
    localparam int M  = NUM_FWD_STAGES;
    localparam int AW = REG_ADDR_WIDTH;
    localparam int CW = FWD_CODE_WIDTH;

    logic [M-1:0]               stage_wen;
    logic [M*AW-1:0]            stage_rd;
    logic [M-1:0]               stage_data_valid;
    logic [N*AW-1:0]            ex_rs;
    logic [N*CW-1:0]            forward_code;
    logic                       ex_data_stall;
    logic                       id_valid;
    logic [N*AW-1:0]            id_rs;
    logic                       id_stall;
    logic                       issue_valid;
    logic [AW-1:0]              issue_rd;
    logic                       issue_ready;
    logic                       complete_valid;
    logic [AW-1:0]              complete_rd;
    logic                       flush;
    logic [STALL_CNT_WIDTH-1:0] stall_count;
    logic                       stall_count_clear;
    logic                       sb_error;

    modport master (
        output stage_wen, stage_rd, stage_data_valid, ex_rs,
        output id_valid, id_rs, issue_valid, issue_rd,
        output complete_valid, complete_rd, flush, stall_count_clear,
        input  forward_code, ex_data_stall, id_stall,
        input  issue_ready, stall_count, sb_error
    );

    modport slave (
        input  stage_wen, stage_rd, stage_data_valid, ex_rs,
        input  id_valid, id_rs, issue_valid, issue_rd,
        input  complete_valid, complete_rd, flush, stall_count_clear,
        output forward_code, ex_data_stall, id_stall,
        output issue_ready, stall_count, sb_error
    );
endinterface

// File: rtl/forwarding_scoreboard.sv
// EX-stage forwarding select (nearest stage wins) plus a per-register
// pending-write scoreboard for long-latency ops and a stall counter.
// Ports: clk, rst (async, active high), bus (forwarding_scoreboard_if.slave):
//   stage_* / ex_rs -> forward_code, ex_data_stall (combinational)
//   id_* / issue_* / complete_* / flush -> id_stall, issue_ready, sb_error
//   stall_count_clear -> stall_count
module forwarding_scoreboard #(
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_FWD_STAGES  = 2,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int FWD_CODE_WIDTH  = 2,
    parameter int PEND_CNT_WIDTH  = 2,
    parameter int STALL_CNT_WIDTH = 16
) (
    input logic clk,
    input logic rst,
    forwarding_scoreboard_if.slave bus
);
    localparam int N    = NUM_READ_PORTS;
    localparam int M    = NUM_FWD_STAGES;
    localparam int AW   = REG_ADDR_WIDTH;
    localparam int CW   = FWD_CODE_WIDTH;
    localparam int NREG = 2 ** AW;

    typedef logic [PEND_CNT_WIDTH-1:0] pend_t;

    pend_t                      pend_q [NREG];
    pend_t                      pend_d [NREG];
    logic                       sb_error_q;
    logic                       sb_error_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

    logic [N*CW-1:0] fwd_code;
    logic            data_stall;
    logic            fwd_hit;
    logic [AW-1:0]   fwd_rs;
    logic [AW-1:0]   fwd_rd;
    logic            id_hit;
    logic [AW-1:0]   id_src;
    logic            ready;
    logic            iss_hit;
    logic            cmp_hit;
    logic            same_reg;

    // Forwarding: scan stages nearest-first; the first match decides,
    // so a not-yet-valid near result blocks an older valid one.
    always_comb begin
        fwd_code   = '0;
        data_stall = 1'b0;
        fwd_hit    = 1'b0;
        fwd_rs     = '0;
        fwd_rd     = '0;
        for (int p = 0; p < N; p++) begin
            fwd_hit = 1'b0;
            fwd_rs  = bus.ex_rs[p*AW +: AW];
            for (int k = 0; k < M; k++) begin
                fwd_rd = bus.stage_rd[k*AW +: AW];
                if (!fwd_hit && bus.stage_wen[k] &&
                    fwd_rd != '0 && fwd_rd == fwd_rs) begin
                    fwd_hit = 1'b1;
                    if (bus.stage_data_valid[k])
                        fwd_code[p*CW +: CW] = CW'(k + 1);
                    else
                        data_stall = 1'b1;
                end
            end
        end
    end

    always_comb begin
        id_hit = 1'b0;
        id_src = '0;
        for (int p = 0; p < N; p++) begin
            id_src = bus.id_rs[p*AW +: AW];
            if (id_src != '0 && pend_q[id_src] != '0)
                id_hit = 1'b1;
        end
    end

    assign ready    = !(bus.issue_valid && pend_q[bus.issue_rd] == '1);
    assign iss_hit  = bus.issue_valid && bus.issue_rd != '0;
    assign cmp_hit  = bus.complete_valid && bus.complete_rd != '0;
    assign same_reg = iss_hit && cmp_hit &&
                      bus.issue_rd == bus.complete_rd;

    // Issue+complete on one register cancel out, even at a full counter.
    always_comb begin
        pend_d     = pend_q;
        sb_error_d = sb_error_q;
        if (!same_reg) begin
            if (iss_hit && ready)
                pend_d[bus.issue_rd] = pend_q[bus.issue_rd] + 1'b1;
            if (cmp_hit) begin
                if (pend_q[bus.complete_rd] == '0)
                    sb_error_d = 1'b1;
                else
                    pend_d[bus.complete_rd] =
                        pend_q[bus.complete_rd] - 1'b1;
            end
        end
        if (bus.flush) begin
            for (int r = 0; r < NREG; r++)
                pend_d[r] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                pend_q[r] <= '0;
            sb_error_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++)
                pend_q[r] <= pend_d[r];
            sb_error_q <= sb_error_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (bus.stall_count_clear)
            stall_cnt_q <= '0;
        else if ((bus.id_stall || data_stall) && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign bus.forward_code  = fwd_code;
    assign bus.ex_data_stall = data_stall;
    assign bus.id_stall      = bus.id_valid && id_hit;
    assign bus.issue_ready   = ready;
    assign bus.stall_count   = stall_cnt_q;
    assign bus.sb_error      = sb_error_q;
endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
Parametrised successor to the two-stage RV32I forwarding logic: selects forwarding sources for N EX-stage read ports across M downstream pipeline stages, with nearest-stage priority. Adds a per-register pending-write scoreboard for long-latency ops (multi-cycle loads, future mul/div), which generates ID-stage stalls and issue back-pressure. Also keeps a saturating stall-cycle performance counter. Sits beside the hazard/control logic between ID and EX.

Parameters:
NUM_READ_PORTS, 2, number of EX/ID source-register ports (N)
NUM_FWD_STAGES, 2, number of downstream stages that can forward (M); stage 1 is nearest EX (MEM), stage M oldest
REG_ADDR_WIDTH, 5, register index width; the scoreboard has 2**REG_ADDR_WIDTH entries
FWD_CODE_WIDTH, 2, forward code width; must satisfy 2**FWD_CODE_WIDTH >= NUM_FWD_STAGES+1
PEND_CNT_WIDTH, 2, width of each per-register outstanding-write counter
STALL_CNT_WIDTH, 16, width of the stall performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
stage_wen  input  M  register-write enable per forwarding stage
stage_rd  input  M*REG_ADDR_WIDTH  destination register per stage (stage k at slice k-1)
stage_data_valid  input  M  stage result is available for forwarding this cycle
ex_rs  input  N*REG_ADDR_WIDTH  EX source registers
forward_code  output  N*FWD_CODE_WIDTH  per port: 0 = register file, k = stage k
ex_data_stall  output  1  some EX port needs a stage result that is not yet valid
id_valid  input  1  ID holds a valid instruction
id_rs  input  N*REG_ADDR_WIDTH  ID source registers
id_stall  output  1  ID source has an outstanding long-latency write
issue_valid  input  1  long-latency op issuing from ID this cycle
issue_rd  input  REG_ADDR_WIDTH  its destination
issue_ready  output  1  scoreboard can accept the issue
complete_valid  input  1  long-latency op writes back this cycle
complete_rd  input  REG_ADDR_WIDTH  its destination
flush  input  1  pipeline flush: clear all pending counters
stall_count  output  STALL_CNT_WIDTH  saturating count of stall cycles
stall_count_clear  input  1  synchronous clear of stall_count
sb_error  output  1  sticky: complete seen on a register with counter 0

Behaviour:
- Forwarding is combinational, zero latency. For port p, find the lowest k with stage_wen[k] && stage_rd[k]!=0 && stage_rd[k]==ex_rs[p].
  - If such k exists and stage_data_valid[k]=1: code = k.
  - If such k exists and stage_data_valid[k]=0: code = 0 and ex_data_stall is asserted. Older stages are never used when a nearer stage matches.
  - No match, or ex_rs[p]==0: code = 0.
- Scoreboard: one PEND_CNT_WIDTH counter per register.
  - Register 0 is never tracked; issue and complete to x0 are ignored.
  - Registered state; outputs derived from it are combinational.
- issue_ready = 0 only when issue_valid and counter[issue_rd] is at its maximum. An issue with issue_ready=0 does not change state.
- Accepted issue increments counter[issue_rd]. Complete decrements counter[complete_rd].
  - Complete on a counter at 0: no change, sb_error set; it clears only on rst.
  - Issue and complete on the same register in the same cycle: net no change (issue accepted even at max).
- id_stall = id_valid && any p with id_rs[p]!=0 && counter[id_rs[p]]!=0.
- flush: all counters to 0 on the next edge. It overrides a simultaneous issue or complete. sb_error is unchanged.
- stall_count: +1 per cycle when id_stall|ex_data_stall, saturating at all-ones. stall_count_clear wins over increment.
- Reset values: all counters 0, stall_count 0, sb_error 0. Hence issue_ready=1 and id_stall=0 after reset. forward_code and ex_data_stall depend only on inputs.
- Reset asserted mid-operation clears state immediately (async); outputs reflect the cleared state while rst is high.

Test Plan:
- Priority: stage1 and stage2 both write x5, both valid, ex_rs0=x5 -> forward_code[0]=1; deassert stage1 wen -> code=2; ex_rs=x0 with stage rd=x0 -> code=0.
- Not-ready load: stage1 wen, rd=x7, data_valid=0, ex_rs1=x7, stage2 also writes x7 and is valid -> forward_code[1]=0, ex_data_stall=1.
- Scoreboard: issue x3; next cycle id_rs0=x3, id_valid=1 -> id_stall=1; complete x3 -> id_stall=0 the cycle after.
- Saturation: with PEND_CNT_WIDTH=2, issue x9 three times -> fourth issue_valid gives issue_ready=0 and counter stays 3; issue and complete x9 together -> count stays 3.
- Error/flush: complete x4 with counter 0 -> sb_error=1 and stays 1; issue x4 then flush together with another issue -> counter 0, id_stall=0.
- Counter/reset: force id_stall for 10 cycles -> stall_count=10; clear together with a stall -> 0; assert rst mid-stall asynchronously -> stall_count=0, sb_error=0, all counters 0.
